// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    // Default geometry: 16 architectural registers, EX/MEM/WB tracked.
    localparam int REG_W_DEF = 4;
    localparam int DEPTH_DEF = 3;

    // Destination field is sized for the widest supported register index;
    // narrower REG_W values are zero-extended into it.
    localparam int REG_W_MAX = 8;

    // Width of the forwarding selects and the pending count (DEPTH <= 6).
    localparam int SEL_W = 3;

    // Forward select value meaning "read the register file".
    localparam int FWD_NONE = 0;

    // One in-flight instruction as seen from ID.
    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] dest;
        logic                 wb_en;
        logic                 mem_read;
    } entry_t;

    // An entry that will eventually write the register file.
    function automatic logic is_writer(entry_t e);
        return e.valid & e.wb_en;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
);

    // Instruction currently held in ID.
    logic             issue_valid;
    logic             issue_wb_en;
    logic             issue_mem_read;
    logic [REG_W-1:0] issue_dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;

    // Control from EX and from software.
    logic             flush;
    logic             cnt_clr;

    // Scoreboard results.
    logic             hazard;
    logic [SEL_W-1:0] fwd_sel1;
    logic [SEL_W-1:0] fwd_sel2;
    logic [SEL_W-1:0] pending;
    logic [CNT_W-1:0] stall_cnt;

    // ID-stage side.
    modport master (
        output issue_valid, issue_wb_en, issue_mem_read, issue_dest,
        output src1, src2, two_src, flush, cnt_clr,
        input  hazard, fwd_sel1, fwd_sel2, pending, stall_cnt
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_wb_en, issue_mem_read, issue_dest,
        input  src1, src2, two_src, flush, cnt_clr,
        output hazard, fwd_sel1, fwd_sel2, pending, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// Compares one source register against the tracked in-flight writers.
// The last entry is excluded: it writes the regfile this cycle and the
// regfile is write-before-read.
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   en,
    input  logic [REG_W-1:0]       src,
    input  entry_t [DEPTH-1:0]     entries,
    output logic                   any_match,
    output logic                   load_match,
    output logic [SEL_W-1:0]       sel
);

    logic [DEPTH-2:0] hit;

    // Per-entry match against pending writers that have not yet retired.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        hit = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            hit[k] = en & is_writer(entries[k]) & (entries[k].dest == REG_W_MAX'(src));
        end
    end

    // Summarise: any match, load-use on EX, and the youngest matching stage.
    always_comb begin
        any_match  = |hit;
        load_match = hit[0] & entries[0].mem_read;
        sel        = SEL_W'(FWD_NONE);
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (hit[k]) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writers through EX..WB,
// raises the ID stall, drives forwarding selects and counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);

    entry_t [DEPTH-1:0] entries;
    entry_t [DEPTH-1:0] entries_nxt;

    logic             any1, ld1, any2, ld2;
    logic [SEL_W-1:0] sel1, sel2;
    logic             haz_raw;
    logic             hazard;
    logic             accept;
    logic [SEL_W-1:0] fwd1, fwd2;
    logic [SEL_W-1:0] pending_nxt;
    logic [SEL_W-1:0] pending_q;
    logic [CNT_W-1:0] cnt_q;

    sb_match #(.REG_W(REG_W), .DEPTH(DEPTH)) u_match1 (
        .en         (bus.issue_valid),
        .src        (bus.src1),
        .entries    (entries),
        .any_match  (any1),
        .load_match (ld1),
        .sel        (sel1)
    );

    sb_match #(.REG_W(REG_W), .DEPTH(DEPTH)) u_match2 (
        .en         (bus.issue_valid & bus.two_src),
        .src        (bus.src2),
        .entries    (entries),
        .any_match  (any2),
        .load_match (ld2),
        .sel        (sel2)
    );

    // Stall rule and forwarding selects for the configured mode.
    always_comb begin
        if (FWD_EN != 0) begin
            haz_raw = ld1 | ld2;
            fwd1    = sel1;
            fwd2    = sel2;
        end else begin
            haz_raw = any1 | any2;
            fwd1    = SEL_W'(FWD_NONE);
            fwd2    = SEL_W'(FWD_NONE);
        end
    end

    // A killed instruction never stalls and never enters EX.
    assign hazard = haz_raw & ~bus.flush;
    assign accept = bus.issue_valid & ~hazard & ~bus.flush;

    // Next pipeline contents and the writer count they will hold.
    always_comb begin
        entries_nxt[0] = '0;
        if (accept) begin
            entries_nxt[0].valid    = 1'b1;
            entries_nxt[0].dest     = REG_W_MAX'(bus.issue_dest);
            entries_nxt[0].wb_en    = bus.issue_wb_en;
            entries_nxt[0].mem_read = bus.issue_mem_read;
        end
        for (int i = 1; i < DEPTH; i++) begin
            entries_nxt[i] = entries[i-1];
        end
        pending_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_nxt = pending_nxt + SEL_W'(is_writer(entries_nxt[i]));
        end
    end

    // Shift the tracked stages and register the pending count with them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the whole entry array is reset, since a stale valid bit would raise a false stall.
            entries   <= '0;
            pending_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            entries   <= entries_nxt;
            pending_q <= pending_nxt;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (hazard && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.hazard    = hazard;
    assign bus.fwd_sel1  = fwd1;
    assign bus.fwd_sel2  = fwd2;
    assign bus.pending   = pending_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: one stall-only scoreboard (CNT_W=4) and one
// forwarding scoreboard (CNT_W=16) driven by the same ID-stage stimulus,
// checked against a last-writer-timestamp model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       iv, wb, ld, two, fl, clr;
    logic [3:0] dest, s1, s2;

    int n_vec = 0;
    int n_bad = 0;

    hazard_scoreboard_if #(.REG_W(4), .CNT_W(4))  if0 ();
    hazard_scoreboard_if #(.REG_W(4), .CNT_W(16)) if1 ();

    hazard_scoreboard #(.REG_W(4), .DEPTH(DEPTH), .FWD_EN(0), .CNT_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    hazard_scoreboard #(.REG_W(4), .DEPTH(DEPTH), .FWD_EN(1), .CNT_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    assign if0.issue_valid = iv;    assign if1.issue_valid = iv;
    assign if0.issue_wb_en = wb;    assign if1.issue_wb_en = wb;
    assign if0.issue_mem_read = ld; assign if1.issue_mem_read = ld;
    assign if0.issue_dest = dest;   assign if1.issue_dest = dest;
    assign if0.src1 = s1;           assign if1.src1 = s1;
    assign if0.src2 = s2;           assign if1.src2 = s2;
    assign if0.two_src = two;       assign if1.two_src = two;
    assign if0.flush = fl;          assign if1.flush = fl;
    assign if0.cnt_clr = clr;       assign if1.cnt_clr = clr;

    always #5 clk = ~clk;

    // Reference model: for each register, the edge at which its youngest
    // writer was accepted; an instruction accepted at edge c sits in stage
    // (cyc - c - 1). Mode 0 = stall-only, mode 1 = forwarding.
    int cyc;
    int last_cyc [2][16];
    bit last_ld  [2][16];
    int wt0[$];
    int wt1[$];
    int scnt [2];
    int smax [2] = '{15, 65535};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_eval(input int m, output bit haz, output int f1, output int f2);
        int a1, a2;
        bit m1, m2, l1, l2;
        a1 = cyc - last_cyc[m][s1] - 1;
        a2 = cyc - last_cyc[m][s2] - 1;
        m1 = iv && (a1 >= 0) && (a1 <= DEPTH - 2);
        m2 = iv && two && (a2 >= 0) && (a2 <= DEPTH - 2);
        l1 = m1 && (a1 == 0) && last_ld[m][s1];
        l2 = m2 && (a2 == 0) && last_ld[m][s2];
        if (m == 0) begin
            haz = (m1 || m2) && !fl;
            f1  = 0;
            f2  = 0;
        end else begin
            haz = (l1 || l2) && !fl;
            f1  = m1 ? a1 + 1 : 0;
            f2  = m2 ? a2 + 1 : 0;
        end
    endfunction

    function automatic int model_pending(input int m);
        int n = 0;
        if (m == 0) begin
            foreach (wt0[i]) if (wt0[i] >= cyc - DEPTH) n++;
        end else begin
            foreach (wt1[i]) if (wt1[i] >= cyc - DEPTH) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 16; r++) begin
                last_cyc[m][r] = -100;
                last_ld[m][r]  = 1'b0;
            end
            scnt[m] = 0;
        end
        wt0.delete();
        wt1.delete();
    endtask

    task automatic model_update();
        bit h;
        int f1, f2;
        for (int m = 0; m < 2; m++) begin
            model_eval(m, h, f1, f2);
            if (clr) scnt[m] = 0;
            else if (h && scnt[m] < smax[m]) scnt[m]++;
            if (iv && !h && !fl && wb) begin
                last_cyc[m][dest] = cyc;
                last_ld[m][dest]  = ld;
                if (m == 0) wt0.push_back(cyc); else wt1.push_back(cyc);
            end
        end
        cyc++;
        while (wt0.size() > 0 && wt0[0] < cyc - DEPTH) void'(wt0.pop_front());
        while (wt1.size() > 0 && wt1[0] < cyc - DEPTH) void'(wt1.pop_front());
    endtask

    task automatic model_check();
        bit h;
        int f1, f2;
        for (int m = 0; m < 2; m++) begin
            model_eval(m, h, f1, f2);
            check($sformatf("m%0d hazard", m),   m == 0 ? 32'(if0.hazard)    : 32'(if1.hazard),    32'(h));
            check($sformatf("m%0d fwd_sel1", m), m == 0 ? 32'(if0.fwd_sel1)  : 32'(if1.fwd_sel1),  32'(f1));
            check($sformatf("m%0d fwd_sel2", m), m == 0 ? 32'(if0.fwd_sel2)  : 32'(if1.fwd_sel2),  32'(f2));
            check($sformatf("m%0d pending", m),  m == 0 ? 32'(if0.pending)   : 32'(if1.pending),   32'(model_pending(m)));
            check($sformatf("m%0d stall_cnt", m), m == 0 ? 32'(if0.stall_cnt) : 32'(if1.stall_cnt), 32'(scnt[m]));
        end
    endtask

    task automatic idle();
        iv = 0; wb = 0; ld = 0; dest = 0; s1 = 0; s2 = 0; two = 0; fl = 0; clr = 0;
    endtask

    task automatic set_issue(input bit w, input bit l, input int d, input int a, input int b, input bit t);
        iv = 1; wb = w; ld = l; dest = 4'(d); s1 = 4'(a); s2 = 4'(b); two = t; fl = 0; clr = 0;
    endtask

    // Sample at the falling edge and compare every output with the model.
    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    // Take the rising edge and advance the model with the same inputs.
    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst hazard0",  32'(if0.hazard),    32'd0);
        check("rst pending0", 32'(if0.pending),   32'd0);
        check("rst cnt0",     32'(if0.stall_cnt), 32'd0);
        check("rst hazard1",  32'(if1.hazard),    32'd0);
        check("rst pending1", 32'(if1.pending),   32'd0);
        check("rst cnt1",     32'(if1.stall_cnt), 32'd0);
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        advance();
    endtask

    initial begin
        idle();
        model_reset();

        // Empty after reset.
        do_reset();
        set_issue(0, 0, 0, 3, 4, 1);
        sample();
        check("empty hazard0", 32'(if0.hazard),    32'd0);
        check("empty hazard1", 32'(if1.hazard),    32'd0);
        check("empty fwd1",    32'(if1.fwd_sel1),  32'd0);
        check("empty pending", 32'(if0.pending),   32'd0);
        check("empty cnt",     32'(if0.stall_cnt), 32'd0);
        advance();

        // Stall-only mode: ADD R2 then a consumer of R2 stalls DEPTH-1 cycles.
        do_reset();
        set_issue(1, 0, 2, 0, 0, 0);
        sample(); advance();
        set_issue(0, 0, 0, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("raw stall c%0d", i), 32'(if0.hazard), 32'(i < 2));
            advance();
        end
        idle();
        sample();
        check("raw stall_cnt", 32'(if0.stall_cnt), 32'd2);
        advance();

        // Forwarding mode: ALU writer R5, consumer src2 forwards from EX then MEM.
        do_reset();
        set_issue(1, 0, 5, 0, 0, 0);
        sample(); advance();
        set_issue(0, 0, 0, 0, 5, 1);
        sample();
        check("fwd alu hazard", 32'(if1.hazard),   32'd0);
        check("fwd alu sel ex", 32'(if1.fwd_sel2), 32'd1);
        advance();
        sample();
        check("fwd alu sel mem", 32'(if1.fwd_sel2), 32'd2);
        advance();

        // Forwarding mode: load-use on R7 stalls exactly one cycle.
        do_reset();
        set_issue(1, 1, 7, 0, 0, 0);
        sample(); advance();
        set_issue(0, 0, 0, 7, 0, 0);
        sample();
        check("ldu hazard", 32'(if1.hazard), 32'd1);
        advance();
        sample();
        check("ldu released",  32'(if1.hazard),    32'd0);
        check("ldu sel mem",   32'(if1.fwd_sel1),  32'd2);
        check("ldu stall_cnt", 32'(if1.stall_cnt), 32'd1);
        advance();

        // Flush during a load-use stall: no stall, bubble, only the load pending.
        do_reset();
        set_issue(1, 1, 1, 0, 0, 0);
        sample(); advance();
        set_issue(0, 0, 0, 1, 0, 0);
        fl = 1;
        sample();
        check("flush hazard", 32'(if1.hazard), 32'd0);
        advance();
        idle();
        sample();
        check("flush pending", 32'(if1.pending),   32'd1);
        check("flush no count", 32'(if1.stall_cnt), 32'd0);
        advance();

        // Saturation: 20 stall cycles on a 4-bit counter, then clear under stall.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            set_issue(1, 0, 9, 0, 0, 0);
            sample(); advance();
            set_issue(0, 0, 0, 9, 0, 0);
            repeat (3) begin sample(); advance(); end
        end
        idle();
        sample();
        check("sat stall_cnt", 32'(if0.stall_cnt), 32'd15);
        advance();
        set_issue(1, 0, 9, 0, 0, 0);
        sample(); advance();
        set_issue(0, 0, 0, 9, 0, 0);
        clr = 1;
        sample();
        check("clr under hazard", 32'(if0.hazard), 32'd1);
        advance();
        clr = 0;
        sample();
        check("clr stall_cnt", 32'(if0.stall_cnt), 32'd0);
        advance();

        // Reset in the middle of a stall drops hazard without a clock edge.
        do_reset();
        set_issue(1, 0, 2, 0, 0, 0);
        sample(); advance();
        set_issue(0, 0, 0, 2, 0, 0);
        sample();
        check("pre-reset stall", 32'(if0.hazard), 32'd1);
        do_reset();
        sample();
        check("post-reset pending", 32'(if0.pending), 32'd0);
        advance();

        // Randomised traffic on a few registers to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            iv   = ($urandom_range(3) != 0);
            wb   = $urandom_range(1);
            ld   = ($urandom_range(2) == 0);
            dest = 4'($urandom_range(3));
            s1   = 4'($urandom_range(3));
            s2   = 4'($urandom_range(3));
            two  = $urandom_range(1);
            fl   = ($urandom_range(7) == 0);
            clr  = ($urandom_range(31) == 0);
            sample();
            advance();
            if (n == 300) do_reset();
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
